// File: rtl/arb_req_pkg.sv
// arb_req_pkg: shared defaults, channel state type and width helper for the
// requester-side arbiter agent. ARB_REQ_STARVE_EN adds the starvation default.
package arb_req_pkg;

  localparam int unsigned ARB_N_DEF     = 5;
  localparam int unsigned ARB_CNT_W_DEF = 3;
  localparam int unsigned ARB_BURST_DEF = 4;
`ifdef ARB_REQ_STARVE_EN
  localparam int unsigned ARB_STARVE_LIMIT_DEF = 15;
`endif

  // A channel is ACTIVE exactly when it has at least one pending job.
  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } chan_state_e;

  // Bits needed to hold values 0..max_val (never less than one bit).
  function automatic int unsigned width_for(input int unsigned max_val);
    int unsigned w;
    if (max_val < 32'd2) begin
      w = 32'd1;
    end else begin
      w = $clog2(max_val + 32'd1);
    end
    return w;
  endfunction

endpackage

// File: rtl/arb_req_agent_if.sv
// arb_req_agent_if: request/grant bus between client, agent and arbiter.
// master = agent side, slave = client/arbiter side.
interface arb_req_agent_if
  import arb_req_pkg::*;
#(
  parameter int unsigned N = ARB_N_DEF
) ();

  logic [N-1:0] enq;
  logic [N-1:0] grt;
  logic [N-1:0] req;
  logic [N-1:0] done;
  logic [N-1:0] full;
  logic [N-1:0] ovf;
  logic [N-1:0] starve;

  modport master (
    input  enq,
    input  grt,
    output req,
    output done,
    output full,
    output ovf,
    output starve
  );

  modport slave (
    output enq,
    output grt,
    input  req,
    input  done,
    input  full,
    input  ovf,
    input  starve
  );

endinterface

// File: rtl/arb_req_chan.sv
// arb_req_chan: one requester channel. Holds the pending-job count, the beat
// count within the current burst and the IDLE/ACTIVE state. With
// ARB_REQ_STARVE_EN a saturating wait counter drives starve; otherwise starve
// is tied low and no counter exists.
module arb_req_chan
  import arb_req_pkg::*;
#(
  parameter int unsigned CNT_W = ARB_CNT_W_DEF,
  parameter int unsigned BURST = ARB_BURST_DEF
`ifdef ARB_REQ_STARVE_EN
  ,
  parameter int unsigned STARVE_LIMIT = ARB_STARVE_LIMIT_DEF
`endif
) (
  input  logic clk,
  input  logic rst_,
  input  logic i_enq,
  input  logic i_grt,
  output logic o_req,
  output logic o_done,
  output logic o_full,
  output logic o_ovf,
  output logic o_starve
);

  localparam int unsigned        BEAT_W    = width_for(BURST - 32'd1);
  localparam logic [CNT_W-1:0]   PEND_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]   PEND_ONE  = CNT_W'(1);
  localparam logic [BEAT_W-1:0]  BEAT_LAST = BEAT_W'(BURST - 32'd1);
  localparam logic [BEAT_W-1:0]  BEAT_ONE  = BEAT_W'(1);

  chan_state_e        r_state;
  logic [CNT_W-1:0]   r_pend;
  logic [BEAT_W-1:0]  r_beat;
  logic               r_done;
  logic               r_full;
  logic               r_ovf;

  chan_state_e        w_state_nxt;
  logic [CNT_W-1:0]   w_pend_nxt;
  logic [BEAT_W-1:0]  w_beat_nxt;
  logic               w_ovf_nxt;
  logic               w_beat;
  logic               w_last;

  // A beat needs our own request; a grant without request is ignored.
  assign w_beat = (r_state == ACTIVE) & i_grt;
  assign w_last = w_beat & (r_beat == BEAT_LAST);

  // Next pending count, beat position, state and overflow pulse.
  always_comb begin
    w_pend_nxt  = r_pend;
    w_ovf_nxt   = 1'b0;
    w_beat_nxt  = r_beat;
    w_state_nxt = r_state;

    case ({i_enq, w_last})
      2'b10: begin
        if (r_pend == PEND_MAX) begin
          w_ovf_nxt = 1'b1;
        end else begin
          w_pend_nxt = r_pend + PEND_ONE;
        end
      end
      2'b01:   w_pend_nxt = r_pend - PEND_ONE;
      // 2'b11: new job replaces the completed one; 2'b00: nothing happens.
      default: w_pend_nxt = r_pend;
    endcase

    // Preemption (grant lost mid-burst) simply holds the beat count.
    if (w_last) begin
      w_beat_nxt = {BEAT_W{1'b0}};
    end else if (w_beat) begin
      w_beat_nxt = r_beat + BEAT_ONE;
    end else begin
      w_beat_nxt = r_beat;
    end

    if (w_pend_nxt != {CNT_W{1'b0}}) begin
      w_state_nxt = ACTIVE;
    end else begin
      w_state_nxt = IDLE;
    end
  end

  // Channel state register; reset discards any burst in progress.
  always_ff @(posedge clk) begin
    if (rst_) begin
      r_state <= IDLE;
      r_pend  <= {CNT_W{1'b0}};
      r_beat  <= {BEAT_W{1'b0}};
      r_done  <= 1'b0;
      r_full  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pend  <= w_pend_nxt;
      r_beat  <= w_beat_nxt;
      r_done  <= w_last;
      r_full  <= (w_pend_nxt == PEND_MAX);
      r_ovf   <= w_ovf_nxt;
    end
  end

  assign o_req  = (r_state == ACTIVE);
  assign o_done = r_done;
  assign o_full = r_full;
  assign o_ovf  = r_ovf;

`ifdef ARB_REQ_STARVE_EN
  localparam int unsigned       WAIT_W   = width_for(STARVE_LIMIT);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(STARVE_LIMIT);
  localparam logic [WAIT_W-1:0] WAIT_ONE = WAIT_W'(1);

  logic [WAIT_W-1:0] r_wait;
  logic              r_starve;
  logic [WAIT_W-1:0] w_wait_nxt;
  logic              w_starve_nxt;

  // Saturating wait counter and sticky starve flag, both cleared by a beat.
  always_comb begin
    w_wait_nxt   = r_wait;
    w_starve_nxt = r_starve;
    if (w_beat || (r_state == IDLE)) begin
      w_wait_nxt = {WAIT_W{1'b0}};
    end else if (r_wait == WAIT_MAX) begin
      w_wait_nxt = r_wait;
    end else begin
      w_wait_nxt = r_wait + WAIT_ONE;
    end

    if (w_beat || (r_state == IDLE)) begin
      w_starve_nxt = 1'b0;
    end else if (w_wait_nxt == WAIT_MAX) begin
      w_starve_nxt = 1'b1;
    end else begin
      w_starve_nxt = r_starve;
    end
  end

  // Wait counter and starve register.
  always_ff @(posedge clk) begin
    if (rst_) begin
      r_wait   <= {WAIT_W{1'b0}};
      r_starve <= 1'b0;
    end else begin
      r_wait   <= w_wait_nxt;
      r_starve <= w_starve_nxt;
    end
  end

  assign o_starve = r_starve;
`else
  assign o_starve = 1'b0;
`endif

endmodule

// File: rtl/arb_req_agent.sv
// arb_req_agent: requester-side agent for the N-way fixed-priority arbiter.
// Generates N independent channels and concatenates their outputs onto the
// bus. Optional starvation detection is enabled by ARB_REQ_STARVE_EN.
module arb_req_agent
  import arb_req_pkg::*;
#(
  parameter int unsigned N     = ARB_N_DEF,
  parameter int unsigned CNT_W = ARB_CNT_W_DEF,
  parameter int unsigned BURST = ARB_BURST_DEF
`ifdef ARB_REQ_STARVE_EN
  ,
  parameter int unsigned STARVE_LIMIT = ARB_STARVE_LIMIT_DEF
`endif
) (
  input  logic               clk,
  input  logic               rst_,
  arb_req_agent_if.master    bus
);

  logic [N-1:0] w_req;
  logic [N-1:0] w_done;
  logic [N-1:0] w_full;
  logic [N-1:0] w_ovf;
  logic [N-1:0] w_starve;

  for (genvar g = 0; g < N; g++) begin : g_chan
    arb_req_chan #(
      .CNT_W        (CNT_W),
      .BURST        (BURST)
`ifdef ARB_REQ_STARVE_EN
      ,
      .STARVE_LIMIT (STARVE_LIMIT)
`endif
    ) u_chan (
      .clk      (clk),
      .rst_     (rst_),
      .i_enq    (bus.enq[g]),
      .i_grt    (bus.grt[g]),
      .o_req    (w_req[g]),
      .o_done   (w_done[g]),
      .o_full   (w_full[g]),
      .o_ovf    (w_ovf[g]),
      .o_starve (w_starve[g])
    );
  end

  assign bus.req    = w_req;
  assign bus.done   = w_done;
  assign bus.full   = w_full;
  assign bus.ovf    = w_ovf;
  assign bus.starve = w_starve;

endmodule

// File: tb/tb_arb_req_agent.sv
// tb_arb_req_agent: table-driven bench with a scoreboard queue for the
// requester agent, plus a hand-written wait/starvation sequence on channel 4.
module tb_arb_req_agent;
  import arb_req_pkg::*;

  localparam int unsigned N = 5;
`ifdef ARB_REQ_STARVE_EN
  localparam bit STARVE_ON = 1'b1;
`else
  localparam bit STARVE_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_;

  always #5 clk = ~clk;

  arb_req_agent_if #(.N(N)) bus ();

  arb_req_agent #(.N(N), .CNT_W(3), .BURST(4)) dut (
    .clk  (clk),
    .rst_ (rst_),
    .bus  (bus)
  );

  typedef struct {
    logic         rst;
    logic [N-1:0] enq;
    logic [N-1:0] grt;
    logic [N-1:0] req;
    logic [N-1:0] done;
    logic [N-1:0] full;
    logic [N-1:0] ovf;
  } vec_t;

  typedef struct {
    logic [N-1:0] req;
    logic [N-1:0] done;
    logic [N-1:0] full;
    logic [N-1:0] ovf;
    logic [N-1:0] starve;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  function automatic exp_t mk_exp(input logic [N-1:0] rq, input logic [N-1:0] dn,
                                  input logic [N-1:0] fl, input logic [N-1:0] ov,
                                  input logic [N-1:0] sv);
    exp_t e;
    e.req = rq; e.done = dn; e.full = fl; e.ovf = ov; e.starve = sv;
    return e;
  endfunction

  // Drive one cycle of inputs, queue the expectation, compare after the edge.
  task automatic drive(input string tag, input logic r, input logic [N-1:0] e,
                       input logic [N-1:0] g, input exp_t x);
    exp_t y;
    rst_    = r;
    bus.enq = e;
    bus.grt = g;
    sb.push_back(x);
    @(posedge clk);
    #1;
    y = sb.pop_front();
    chk({tag, ".req"},    bus.req,    y.req);
    chk({tag, ".done"},   bus.done,   y.done);
    chk({tag, ".full"},   bus.full,   y.full);
    chk({tag, ".ovf"},    bus.ovf,    y.ovf);
    chk({tag, ".starve"}, bus.starve, y.starve);
  endtask

  task automatic row(input logic r, input logic [N-1:0] e, input logic [N-1:0] g,
                     input logic [N-1:0] rq, input logic [N-1:0] dn,
                     input logic [N-1:0] fl, input logic [N-1:0] ov);
    vec_t v;
    v.rst = r; v.enq = e; v.grt = g; v.req = rq; v.done = dn; v.full = fl; v.ovf = ov;
    tbl.push_back(v);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic         seen;
    logic [N-1:0] sv;
    rst_    = 1'b1;
    bus.enq = 5'b00000;
    bus.grt = 5'b00000;

    // Reset state; an enq under reset is ignored.
    row(1'b1, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000);
    row(1'b1, 5'b00001, 5'b11111, 5'b00000, 5'b00000, 5'b00000, 5'b00000);
    // Single job on ch0 (grant to idle channels is stray and ignored).
    row(1'b0, 5'b00001, 5'b11111, 5'b00001, 5'b00000, 5'b00000, 5'b00000);
    for (int k = 0; k < 3; k++)
      row(1'b0, 5'b00000, 5'b11111, 5'b00001, 5'b00000, 5'b00000, 5'b00000);
    row(1'b0, 5'b00000, 5'b11111, 5'b00000, 5'b00001, 5'b00000, 5'b00000);
    row(1'b0, 5'b00000, 5'b11111, 5'b00000, 5'b00000, 5'b00000, 5'b00000);
    // Back-to-back jobs on ch1.
    row(1'b0, 5'b00010, 5'b11111, 5'b00010, 5'b00000, 5'b00000, 5'b00000);
    row(1'b0, 5'b00010, 5'b11111, 5'b00010, 5'b00000, 5'b00000, 5'b00000);
    for (int k = 0; k < 2; k++)
      row(1'b0, 5'b00000, 5'b11111, 5'b00010, 5'b00000, 5'b00000, 5'b00000);
    row(1'b0, 5'b00000, 5'b11111, 5'b00010, 5'b00010, 5'b00000, 5'b00000);
    for (int k = 0; k < 3; k++)
      row(1'b0, 5'b00000, 5'b11111, 5'b00010, 5'b00000, 5'b00000, 5'b00000);
    row(1'b0, 5'b00000, 5'b11111, 5'b00000, 5'b00010, 5'b00000, 5'b00000);
    row(1'b0, 5'b00000, 5'b11111, 5'b00000, 5'b00000, 5'b00000, 5'b00000);
    // Preemption on ch2: grant missing for two cycles mid-burst.
    row(1'b0, 5'b00100, 5'b00100, 5'b00100, 5'b00000, 5'b00000, 5'b00000);
    row(1'b0, 5'b00000, 5'b00100, 5'b00100, 5'b00000, 5'b00000, 5'b00000);
    row(1'b0, 5'b00000, 5'b00000, 5'b00100, 5'b00000, 5'b00000, 5'b00000);
    row(1'b0, 5'b00000, 5'b00000, 5'b00100, 5'b00000, 5'b00000, 5'b00000);
    row(1'b0, 5'b00000, 5'b00100, 5'b00100, 5'b00000, 5'b00000, 5'b00000);
    row(1'b0, 5'b00000, 5'b00100, 5'b00100, 5'b00000, 5'b00000, 5'b00000);
    row(1'b0, 5'b00000, 5'b00100, 5'b00000, 5'b00100, 5'b00000, 5'b00000);
    row(1'b0, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000);
    // Overflow on ch3: 8 enqueues with no grant.
    for (int k = 0; k < 6; k++)
      row(1'b0, 5'b01000, 5'b00000, 5'b01000, 5'b00000, 5'b00000, 5'b00000);
    row(1'b0, 5'b01000, 5'b00000, 5'b01000, 5'b00000, 5'b01000, 5'b00000);
    row(1'b0, 5'b01000, 5'b00000, 5'b01000, 5'b00000, 5'b01000, 5'b01000);
    row(1'b0, 5'b00000, 5'b00000, 5'b01000, 5'b00000, 5'b01000, 5'b00000);
    for (int k = 0; k < 3; k++)
      row(1'b0, 5'b00000, 5'b01000, 5'b01000, 5'b00000, 5'b01000, 5'b00000);
    // Enqueue at max together with a last beat: kept, count unchanged.
    row(1'b0, 5'b01000, 5'b01000, 5'b01000, 5'b01000, 5'b01000, 5'b00000);
    row(1'b0, 5'b00000, 5'b00000, 5'b01000, 5'b00000, 5'b01000, 5'b00000);
    // Reset mid-burst on ch0 while ch3 is still full; no done afterwards.
    row(1'b0, 5'b00001, 5'b00001, 5'b01001, 5'b00000, 5'b01000, 5'b00000);
    row(1'b0, 5'b00000, 5'b00001, 5'b01001, 5'b00000, 5'b01000, 5'b00000);
    row(1'b1, 5'b00000, 5'b00001, 5'b00000, 5'b00000, 5'b00000, 5'b00000);
    for (int k = 0; k < 4; k++)
      row(1'b0, 5'b00000, 5'b00001, 5'b00000, 5'b00000, 5'b00000, 5'b00000);

    for (int k = 0; k < tbl.size(); k++) begin
      drive($sformatf("row%0d", k), tbl[k].rst, tbl[k].enq, tbl[k].grt,
            mk_exp(tbl[k].req, tbl[k].done, tbl[k].full, tbl[k].ovf, 5'b00000));
    end

    // Channel 4 waits 20 cycles without a grant.
    drive("wait0", 1'b0, 5'b10000, 5'b00000,
          mk_exp(5'b10000, 5'b00000, 5'b00000, 5'b00000, 5'b00000));
    for (int k = 1; k <= 20; k++) begin
      sv = (STARVE_ON && (k >= 15)) ? 5'b10000 : 5'b00000;
      drive($sformatf("wait%0d", k), 1'b0, 5'b00000, 5'b00000,
            mk_exp(5'b10000, 5'b00000, 5'b00000, 5'b00000, sv));
    end
    // One beat clears starve on the following cycle.
    drive("first_beat", 1'b0, 5'b00000, 5'b10000,
          mk_exp(5'b10000, 5'b00000, 5'b00000, 5'b00000, 5'b00000));

    // Finish the burst with a bounded wait for done[4].
    seen = 1'b0;
    for (int c = 0; c < 8 && !seen; c++) begin
      bus.grt = 5'b10000;
      @(posedge clk);
      #1;
      if (bus.done[4]) seen = 1'b1;
    end
    chk("ch4_done_seen", {4'b0000, seen}, 5'b00001);
    chk("ch4_req_released", bus.req, 5'b00000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
